// File: rtl/spi_reg_bridge.sv
// SPI-slave (mode 0) to register-bus bridge with burst, read handshake and error reporting.
// Optional odd parity per data word: define SPI_REG_BRIDGE_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for SSB fall
// HDR    | shifting header (rw, burst)
// ADDR   | shifting address
// WDATA  | shifting write data word(s)
// RDWAIT | read requested, waiting for rd_ack or first data SCLK fall
// RDATA  | shifting read data out on MISO
module spi_reg_bridge #(
    parameter int HDR_W       = 2,
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_100mhz,
    input  logic              rst_n_eim,
    input  logic              SCLK,
    input  logic              SSB,
    input  logic              MOSI,
    output logic              MISO,
    output logic              miso_oe,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err_flag,
    output logic [15:0]       pkt_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_RDWAIT = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;

`ifdef SPI_REG_BRIDGE_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_W;
    localparam int SH_A   = (HDR_W > ADDR_W) ? HDR_W : ADDR_W;
    localparam int SH_W   = (SH_A > WORD_W) ? SH_A : WORD_W;
    localparam int CNT_W  = $clog2(SH_W + 1);

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync, ssb_sync, mosi_sync;
    logic                   sclk_d, ssb_d;
    logic                   sclk_s, ssb_s, mosi_s;
    logic                   sclk_rise, sclk_fall, ssb_rise, ssb_fall;

    logic [2:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SH_W-2:0]   shift_in;
    logic [SH_W-1:0]   nxt_sh;
    logic [WORD_W-1:0] out_sh;
    logic [ADDR_W-1:0] addr;
    logic              rw, burst, done;
    logic              abort_err;

    logic [DATA_W-1:0] wr_word;
    logic              wr_par_ok;
    logic [DATA_W-1:0] rd_src;
    logic [WORD_W-1:0] rd_load;

    // SSB chain resets high so reset never looks like a select
    always_ff @(posedge clk_100mhz or negedge rst_n_eim) begin
        if (!rst_n_eim) begin
            sclk_sync <= '0;
            ssb_sync  <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ssb_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ssb_sync  <= {ssb_sync[SYNC_STAGES-2:0], SSB};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_s;
            ssb_d     <= ssb_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ssb_s     = ssb_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ssb_rise  = ssb_s & ~ssb_d;
    assign ssb_fall  = ~ssb_s & ssb_d;
    assign busy      = ~ssb_s;
    assign nxt_sh    = {shift_in, mosi_s};
    assign rd_src    = rd_ack ? rd_data : '0;

`ifdef SPI_REG_BRIDGE_PARITY_EN
    assign wr_word   = nxt_sh[DATA_W:1];
    assign wr_par_ok = ^nxt_sh[DATA_W:0];
    assign rd_load   = {rd_src, ~^rd_src};
`else
    assign wr_word   = nxt_sh[DATA_W-1:0];
    assign wr_par_ok = 1'b1;
    assign rd_load   = rd_src;
`endif

    // Deselect with bits of an unfinished header/address/data word pending
    assign abort_err = ((state == S_HDR) && (bit_cnt != '0)) ||
                       (state == S_ADDR) ||
                       (((state == S_WDATA) || (state == S_RDATA)) && !done && (bit_cnt != '0));

    always_ff @(posedge clk_100mhz or negedge rst_n_eim) begin
        if (!rst_n_eim) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shift_in <= '0;
            out_sh   <= '0;
            addr     <= '0;
            rw       <= 1'b0;
            burst    <= 1'b0;
            done     <= 1'b0;
            MISO     <= 1'b0;
            miso_oe  <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_req   <= 1'b0;
            rd_addr  <= '0;
            err_flag <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            wr_en  <= 1'b0;
            rd_req <= 1'b0;
            if (sclk_rise) shift_in <= nxt_sh[SH_W-2:0];

            if (ssb_rise) begin
                if (abort_err) err_flag <= 1'b1;
                state   <= S_IDLE;
                bit_cnt <= '0;
                done    <= 1'b0;
                MISO    <= 1'b0;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ssb_fall) begin
                            state    <= S_HDR;
                            bit_cnt  <= '0;
                            done     <= 1'b0;
                            err_flag <= 1'b0;
                        end
                    end
                    S_HDR: begin
                        if (sclk_rise) begin
                            if (bit_cnt == HDR_LAST) begin
                                rw      <= nxt_sh[HDR_W-1];
                                burst   <= nxt_sh[HDR_W-2];
                                bit_cnt <= '0;
                                state   <= S_ADDR;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sclk_rise) begin
                            if (bit_cnt == ADDR_LAST) begin
                                addr    <= nxt_sh[ADDR_W-1:0];
                                bit_cnt <= '0;
                                if (rw) begin
                                    rd_req  <= 1'b1;
                                    rd_addr <= nxt_sh[ADDR_W-1:0];
                                    state   <= S_RDWAIT;
                                end else begin
                                    state <= S_WDATA;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_WDATA: begin
                        if (sclk_rise && !done) begin
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt <= '0;
                                if (wr_par_ok) begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= addr;
                                    wr_data <= wr_word;
                                    pkt_cnt <= pkt_cnt + 16'd1;
                                end else begin
                                    err_flag <= 1'b1;
                                end
                                if (burst) addr <= addr + ADDR_W'(1);
                                else       done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_RDWAIT: begin
                        // A fall here is the MSB slot: present it now, zeros if no ack yet
                        if (sclk_fall) begin
                            MISO    <= rd_load[WORD_W-1];
                            out_sh  <= rd_load << 1;
                            miso_oe <= 1'b1;
                            state   <= S_RDATA;
                            if (!rd_ack) err_flag <= 1'b1;
                        end else if (rd_ack) begin
                            out_sh  <= rd_load;
                            miso_oe <= 1'b1;
                            state   <= S_RDATA;
                        end
                    end
                    S_RDATA: begin
                        if (sclk_fall && !done) begin
                            MISO   <= out_sh[WORD_W-1];
                            out_sh <= out_sh << 1;
                        end
                        if (sclk_rise && !done) begin
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt <= '0;
                                pkt_cnt <= pkt_cnt + 16'd1;
                                if (burst) begin
                                    addr    <= addr + ADDR_W'(1);
                                    rd_addr <= addr + ADDR_W'(1);
                                    rd_req  <= 1'b1;
                                    state   <= S_RDWAIT;
                                end else begin
                                    done <= 1'b1;
                                    MISO <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge (default build, no parity).
module tb_spi_reg_bridge;

    localparam int HALF = 100;

    logic        clk_100mhz = 1'b0;
    logic        rst_n_eim;
    logic        SCLK, SSB, MOSI;
    logic        MISO, miso_oe;
    logic        wr_en, rd_req, rd_ack;
    logic [13:0] wr_addr, rd_addr;
    logic [15:0] wr_data, rd_data;
    logic        busy, err_flag;
    logic [15:0] pkt_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] wr_log[$];
    int          rd_cnt   = 0;
    int          both_cnt = 0;
    bit          ack_en   = 1'b1;
    int          ack_dly  = 3;
    logic [63:0] rx;
    logic        oe_all;

    spi_reg_bridge dut (
        .clk_100mhz(clk_100mhz),
        .rst_n_eim (rst_n_eim),
        .SCLK      (SCLK),
        .SSB       (SSB),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .miso_oe   (miso_oe),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .busy      (busy),
        .err_flag  (err_flag),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    always @(negedge clk_100mhz) begin
        if (wr_en) wr_log.push_back({2'b00, wr_addr, wr_data});
        if (wr_en && rd_req) both_cnt++;
    end

    // Register-map model: 0x0040 holds 0xBEEF, every other address returns addr ^ 0xF000
    initial begin
        logic [13:0] a;
        rd_ack  = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk_100mhz);
            if (rd_req) begin
                rd_cnt++;
                a = rd_addr;
                if (ack_en) begin
                    repeat (ack_dly) @(negedge clk_100mhz);
                    rd_data = (a == 14'h0040) ? 16'hBEEF : ({2'b00, a} ^ 16'hF000);
                    rd_ack  = 1'b1;
                    @(negedge clk_100mhz);
                    rd_ack  = 1'b0;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input logic [63:0] tx, input int nbits, input bit keep_low,
                            output logic [63:0] rx_o, output logic oe_o);
        rx_o = '0;
        oe_o = 1'b1;
        SSB  = 1'b0;
        #(HALF);
        for (int i = nbits - 1; i >= 0; i--) begin
            MOSI = tx[i];
            #(HALF);
            SCLK    = 1'b1;
            rx_o[i] = MISO;
            if (i < nbits - 16) oe_o = oe_o & miso_oe;
            #(HALF);
            SCLK = 1'b0;
        end
        MOSI = 1'b0;
        if (!keep_low) begin
            #(HALF);
            SSB = 1'b1;
            #(4 * HALF);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_eim = 1'b0;
        SCLK = 1'b0;
        SSB  = 1'b1;
        MOSI = 1'b0;
        #22;
        check_val("rst_wr_en",   wr_en,   0);
        check_val("rst_rd_req",  rd_req,  0);
        check_val("rst_miso",    MISO,    0);
        check_val("rst_miso_oe", miso_oe, 0);
        check_val("rst_busy",    busy,    0);
        check_val("rst_err",     err_flag, 0);
        check_val("rst_pkt_cnt", pkt_cnt, 0);
        check_val("rst_addrs",   {wr_addr, rd_addr}, 0);
        #20;
        rst_n_eim = 1'b1;
        #100;

        // single write
        spi_xfer({2'b00, 14'h0123, 16'hA5A5}, 32, 1'b0, rx, oe_all);
        check_val("t1_nwr", wr_log.size(), 1);
        check_val("t1_wr", wr_log[0], {2'b00, 14'h0123, 16'hA5A5});
        check_val("t1_pkt", pkt_cnt, 1);
        check_val("t1_err", err_flag, 0);
        check_val("t1_oe", oe_all, 0);

        // burst write with address wrap
        spi_xfer({2'b01, 14'h3FFF, 16'h1111, 16'h2222}, 48, 1'b0, rx, oe_all);
        check_val("t2_nwr", wr_log.size(), 3);
        check_val("t2_wr0", wr_log[1], {2'b00, 14'h3FFF, 16'h1111});
        check_val("t2_wr1", wr_log[2], {2'b00, 14'h0000, 16'h2222});
        check_val("t2_pkt", pkt_cnt, 3);
        check_val("t2_err", err_flag, 0);

        // single read, ack three cycles after request
        ack_dly = 3;
        spi_xfer({2'b10, 14'h0040, 16'h0000}, 32, 1'b0, rx, oe_all);
        check_val("t3_data", rx[15:0], 16'hBEEF);
        check_val("t3_oe", oe_all, 1);
        check_val("t3_nrd", rd_cnt, 1);
        check_val("t3_err", err_flag, 0);
        check_val("t3_pkt", pkt_cnt, 4);
        check_val("t3_oe_end", miso_oe, 0);
        check_val("t3_miso_end", MISO, 0);

        // burst read across the address wrap
        ack_dly = 1;
        spi_xfer({2'b11, 14'h3FFF, 32'h0}, 48, 1'b0, rx, oe_all);
        check_val("t4_word0", rx[31:16], 16'hCFFF);
        check_val("t4_word1", rx[15:0], 16'hF000);
        check_val("t4_oe", oe_all, 1);
        check_val("t4_pkt", pkt_cnt, 6);
        check_val("t4_err", err_flag, 0);
        check_val("t4_nwr", wr_log.size(), 3);

        // read timeout
        ack_en = 1'b0;
        spi_xfer({2'b10, 14'h0055, 16'h0000}, 32, 1'b0, rx, oe_all);
        check_val("t5_data", rx[15:0], 16'h0000);
        check_val("t5_err", err_flag, 1);
        check_val("t5_pkt", pkt_cnt, 7);
        ack_en = 1'b1;

        // next packet clears the error on its SSB fall
        spi_xfer({2'b00, 14'h0002, 16'h1234}, 32, 1'b1, rx, oe_all);
        check_val("t6_err_clr", err_flag, 0);
        check_val("t6_busy", busy, 1);
        #(HALF);
        SSB = 1'b1;
        #(4 * HALF);
        check_val("t6_wr", wr_log[3], {2'b00, 14'h0002, 16'h1234});
        check_val("t6_busy_end", busy, 0);

        // abort after 9 data bits, then a clean write
        spi_xfer({2'b00, 14'h0100, 9'h1FF}, 25, 1'b0, rx, oe_all);
        check_val("t7_nwr", wr_log.size(), 4);
        check_val("t7_err", err_flag, 1);
        check_val("t7_pkt", pkt_cnt, 8);
        spi_xfer({2'b00, 14'h0101, 16'hC3C3}, 32, 1'b0, rx, oe_all);
        check_val("t7_wr", wr_log[4], {2'b00, 14'h0101, 16'hC3C3});
        check_val("t7_err_clr", err_flag, 0);
        check_val("t7_pkt2", pkt_cnt, 9);

        // reset asserted in the middle of a read data phase (ack in the request cycle)
        ack_dly = 0;
        spi_xfer({2'b10, 14'h0007, 4'h0}, 20, 1'b1, rx, oe_all);
        check_val("t8_bits", rx[3:0], 4'hF);
        check_val("t8_pre_miso", MISO, 1);
        check_val("t8_pre_oe", miso_oe, 1);
        check_val("t8_pre_pkt", pkt_cnt, 9);
        rst_n_eim = 1'b0;
        #1;
        check_val("t8_miso", MISO, 0);
        check_val("t8_oe", miso_oe, 0);
        check_val("t8_pkt", pkt_cnt, 0);
        SSB = 1'b1;
        SCLK = 1'b0;
        #50;
        rst_n_eim = 1'b1;
        #200;

        spi_xfer({2'b00, 14'h0ABC, 16'h5A5A}, 32, 1'b0, rx, oe_all);
        check_val("t9_wr", wr_log[5], {2'b00, 14'h0ABC, 16'h5A5A});
        check_val("t9_pkt", pkt_cnt, 1);
        check_val("t9_excl", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
